// File: rtl/debug_dl_ctrl_pkg.sv
// Shared widths, state encodings and helpers for the debug download controller.
// The optional inactivity timeout is built only when DL_TIMEOUT_EN is defined.
package debug_dl_ctrl_pkg;

   localparam int INST_ADDR_BUS = 32;
   localparam int INST_DATA_BUS = 32;
   localparam int DL_CNT_BUS    = 16;
   localparam int DL_TMR_BUS    = 24;

   localparam logic [INST_ADDR_BUS-1:0] MEM_DEPTH_DEFAULT = 32'h0000_4000;

   localparam logic [1:0] DL_RUN   = 2'd0;
   localparam logic [1:0] DL_ARM   = 2'd1;
   localparam logic [1:0] DL_LOAD  = 2'd2;
   localparam logic [1:0] DL_QUIET = 2'd3;

   typedef struct packed {
      logic                     en;
      logic [INST_ADDR_BUS-1:0] addr;
      logic [INST_DATA_BUS-1:0] data;
   } mem_wr_t;

   localparam mem_wr_t MEM_WR_IDLE = '{en: 1'b0, addr: 32'h0000_0000, data: 32'h0000_0000};

   // Loader address is usable when it is word aligned and inside the writable memory.
   function automatic logic dl_addr_ok(input logic [INST_ADDR_BUS-1:0] addr,
                                       input logic [INST_ADDR_BUS-1:0] depth);
      return (addr < depth) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/debug_dl_ctrl_if.sv
// Core / loader / memory-port signal bundle for debug_dl_ctrl.
// master = surrounding system (core, loader, memory); slave = the controller.
interface debug_dl_ctrl_if;
   import debug_dl_ctrl_pkg::*;

   logic                     debug_en_i;
   logic                     dbg_wr_en_i;
   logic [INST_ADDR_BUS-1:0] dbg_wr_addr_i;
   logic [INST_DATA_BUS-1:0] dbg_wr_data_i;
   logic                     core_req_i;
   logic [INST_ADDR_BUS-1:0] core_wr_addr_i;
   logic [INST_DATA_BUS-1:0] core_wr_data_i;
   logic                     core_gnt_o;
   logic                     mem_wr_en_o;
   logic [INST_ADDR_BUS-1:0] mem_wr_addr_o;
   logic [INST_DATA_BUS-1:0] mem_wr_data_o;
   logic                     hold_cpu_o;
   logic                     dl_busy_o;
   logic                     dl_done_o;
   logic [DL_CNT_BUS-1:0]    word_cnt_o;
   logic                     dl_err_o;

   modport master (
      output debug_en_i, dbg_wr_en_i, dbg_wr_addr_i, dbg_wr_data_i,
             core_req_i, core_wr_addr_i, core_wr_data_i,
      input  core_gnt_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
             hold_cpu_o, dl_busy_o, dl_done_o, word_cnt_o, dl_err_o
   );

   modport slave (
      input  debug_en_i, dbg_wr_en_i, dbg_wr_addr_i, dbg_wr_data_i,
             core_req_i, core_wr_addr_i, core_wr_data_i,
      output core_gnt_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
             hold_cpu_o, dl_busy_o, dl_done_o, word_cnt_o, dl_err_o
   );

endinterface

// File: rtl/debug_dl_ctrl_cycle_timer.sv
// Loadable down-counter with a zero flag; shared by the arm-wait, release and
// inactivity-timeout intervals of debug_dl_ctrl.
module dl_cycle_timer #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_r;

   // Count down to zero and park there until reloaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {W{1'b0}};
      end else if (load_i) begin
         cnt_r <= load_val_i;
      end else if (cnt_r != {W{1'b0}}) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero_o = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/debug_dl_ctrl.sv
// Boot/download controller sharing the instruction-memory write port between core and UART loader.
// Define DL_TIMEOUT_EN to end a download after TIMEOUT_CYCLES without loader writes.
module debug_dl_ctrl
   import debug_dl_ctrl_pkg::*;
#(
   parameter logic [INST_ADDR_BUS-1:0] MEM_DEPTH_BYTES = MEM_DEPTH_DEFAULT,
   parameter int unsigned              ARM_WAIT        = 16,
   parameter int unsigned              RELEASE_CYCLES  = 64,
   parameter logic [DL_TMR_BUS-1:0]    TIMEOUT_CYCLES  = 24'd5_000_000
) (
   input  logic          clk,
   input  logic          rst,
   debug_dl_ctrl_if.slave bus
);

   // Timer reload values are interval-1 because the move happens on the zero cycle.
   localparam logic [DL_TMR_BUS-1:0] ARM_LOAD = DL_TMR_BUS'(ARM_WAIT - 32'd1);
   localparam logic [DL_TMR_BUS-1:0] REL_LOAD = DL_TMR_BUS'(RELEASE_CYCLES - 32'd1);
   localparam logic [DL_TMR_BUS-1:0] TMO_LOAD = TIMEOUT_CYCLES - 24'd1;

   logic [1:0]            state_r;
   logic [1:0]            state_nxt_s;
   logic                  tmr_load_s;
   logic [DL_TMR_BUS-1:0] tmr_val_s;
   logic                  tmr_zero_s;
   logic                  arm_req_s;
   logic                  wr_ok_s;
   logic                  wr_acc_s;
   logic                  err_set_s;
   logic                  arm_entry_s;
   logic                  quiet_exit_s;
   mem_wr_t               mem_r;
   logic                  core_gnt_r;
   logic                  hold_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  err_r;
   logic [DL_CNT_BUS-1:0] word_cnt_r;
`ifdef DL_TIMEOUT_EN
   logic                  tmo_hit_s;
   logic                  tmo_lock_r;

   assign arm_req_s = bus.debug_en_i && !tmo_lock_r;
`else
   assign arm_req_s = bus.debug_en_i;
`endif

   assign wr_ok_s      = dl_addr_ok(bus.dbg_wr_addr_i, MEM_DEPTH_BYTES);
   assign wr_acc_s     = (state_r == DL_LOAD) && bus.dbg_wr_en_i && wr_ok_s;
   assign arm_entry_s  = (state_r == DL_RUN) && (state_nxt_s == DL_ARM);
   assign quiet_exit_s = (state_r == DL_QUIET) && (state_nxt_s == DL_RUN);

   dl_cycle_timer #(.W(DL_TMR_BUS)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_val_s),
      .zero_o     (tmr_zero_s)
   );

   // Next state, timer reloads and error-set conditions.
   always_comb begin
      state_nxt_s = state_r;
      tmr_load_s  = 1'b0;
      tmr_val_s   = REL_LOAD;
      err_set_s   = 1'b0;
`ifdef DL_TIMEOUT_EN
      tmo_hit_s   = 1'b0;
`endif
      case (state_r)
         DL_RUN: begin
            if (arm_req_s) begin
               state_nxt_s = DL_ARM;
               tmr_load_s  = 1'b1;
               tmr_val_s   = ARM_LOAD;
            end else begin
               state_nxt_s = DL_RUN;
            end
         end
         DL_ARM: begin
            err_set_s = bus.dbg_wr_en_i;
            if (!bus.debug_en_i) begin
               state_nxt_s = DL_QUIET;
               tmr_load_s  = 1'b1;
               tmr_val_s   = REL_LOAD;
            end else if (!bus.core_req_i) begin
               state_nxt_s = DL_LOAD;
               tmr_load_s  = 1'b1;
               tmr_val_s   = TMO_LOAD;
            end else if (tmr_zero_s) begin
               state_nxt_s = DL_LOAD;
               tmr_load_s  = 1'b1;
               tmr_val_s   = TMO_LOAD;
               err_set_s   = 1'b1;
            end else begin
               state_nxt_s = DL_ARM;
            end
         end
         DL_LOAD: begin
            err_set_s = bus.dbg_wr_en_i && !wr_ok_s;
            if (!bus.debug_en_i) begin
               state_nxt_s = DL_QUIET;
               tmr_load_s  = 1'b1;
               tmr_val_s   = REL_LOAD;
            end else if (bus.dbg_wr_en_i) begin
               state_nxt_s = DL_LOAD;
               tmr_load_s  = 1'b1;
               tmr_val_s   = TMO_LOAD;
`ifdef DL_TIMEOUT_EN
            end else if (tmr_zero_s) begin
               state_nxt_s = DL_QUIET;
               tmr_load_s  = 1'b1;
               tmr_val_s   = REL_LOAD;
               tmo_hit_s   = 1'b1;
               err_set_s   = (word_cnt_r == 16'h0000);
`endif
            end else begin
               state_nxt_s = DL_LOAD;
            end
         end
         DL_QUIET: begin
            if (tmr_zero_s) begin
               state_nxt_s = DL_RUN;
            end else begin
               state_nxt_s = DL_QUIET;
            end
         end
         default: begin
            state_nxt_s = DL_RUN;
         end
      endcase
   end

   // State register and status outputs decoded from the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= DL_RUN;
         core_gnt_r <= 1'b1;
         hold_r     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         core_gnt_r <= (state_nxt_s == DL_RUN);
         hold_r     <= (state_nxt_s != DL_RUN);
         busy_r     <= (state_nxt_s == DL_LOAD);
         done_r     <= quiet_exit_s;
      end
   end

   // Write-port mux keyed on the registered state only, so both masters never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_r <= MEM_WR_IDLE;
      end else begin
         case (state_r)
            DL_RUN, DL_ARM: begin
               mem_r.en <= bus.core_req_i;
               if (bus.core_req_i) begin
                  mem_r.addr <= bus.core_wr_addr_i;
                  mem_r.data <= bus.core_wr_data_i;
               end
            end
            DL_LOAD: begin
               mem_r.en <= wr_acc_s;
               if (wr_acc_s) begin
                  mem_r.addr <= bus.dbg_wr_addr_i;
                  mem_r.data <= bus.dbg_wr_data_i;
               end
            end
            default: begin
               mem_r.en <= 1'b0;
            end
         endcase
      end
   end

   // Download statistics: cleared when a new download arms, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt_r <= 16'h0000;
         err_r      <= 1'b0;
      end else if (arm_entry_s) begin
         word_cnt_r <= 16'h0000;
         err_r      <= 1'b0;
      end else begin
         if (wr_acc_s && (word_cnt_r != 16'hFFFF)) begin
            word_cnt_r <= word_cnt_r + 16'h0001;
         end
         if (err_set_s) begin
            err_r <= 1'b1;
         end
      end
   end

`ifdef DL_TIMEOUT_EN
   // After a timeout debug_en_i must drop before another download may arm.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_lock_r <= 1'b0;
      end else if (tmo_hit_s) begin
         tmo_lock_r <= 1'b1;
      end else if (!bus.debug_en_i) begin
         tmo_lock_r <= 1'b0;
      end else begin
         tmo_lock_r <= tmo_lock_r;
      end
   end
`endif

   assign bus.core_gnt_o    = core_gnt_r;
   assign bus.hold_cpu_o    = hold_r;
   assign bus.dl_busy_o     = busy_r;
   assign bus.dl_done_o     = done_r;
   assign bus.mem_wr_en_o   = mem_r.en;
   assign bus.mem_wr_addr_o = mem_r.addr;
   assign bus.mem_wr_data_o = mem_r.data;
   assign bus.word_cnt_o    = word_cnt_r;
   assign bus.dl_err_o      = err_r;

endmodule
